vgg_layer_sequencer: RTL and testbench
======================================

# vgg_layer_sequencer

Controller that sequences the VGG16 convolution engine through every layer of the network, once per input image. It drives the per-layer dimensions and pool-enable into the shared conv/pool datapath and issues one start pulse per layer. It counts output beats to detect layer completion and stalls the engine when the output FIFO is full. It sits between the stream FIFOs and the datapath inside the accelerator top, replacing per-layer hand editing of widths, heights and layer counts.

## Interface
- `NUM_LAYER`, 13: number of conv layers sequenced per image.
- `NUM_IMG`, 1: images processed per `start`.
- `IMG_WIDTH`, 224: first-layer input width.
- `IMG_HEIGHT`, 224: first-layer input height.
- `DIM_W`, 9: width of the dimension fields.
- `CNT_W`, 16: width of the beat counter; must hold `IMG_WIDTH*IMG_HEIGHT`.
- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a run of `NUM_IMG` images.
- `eng_valid_out` in 1: engine produced one output beat this cycle.
- `out_full` in 1: output FIFO full.
- `eng_start` out 1: one-cycle pulse that starts the current layer.
- `eng_stall` out 1: freezes the engine pipeline.
- `layer_idx` out `$clog2(NUM_LAYER)`: current layer index.
- `img_idx` out `$clog2(NUM_IMG)+1`: current image index.
- `cur_width` out `DIM_W`: input width of the current layer.
- `cur_height` out `DIM_W`: input height of the current layer.
- `cur_pool` out 1: current layer ends with 2x2 max-pool.
- `busy` out 1: high from the `start` acceptance until `done`.
- `done` out 1: one-cycle pulse after the last layer of the last image.

## Operation
- **FSM states:** IDLE → LOAD → KICK → RUN → NEXT → (LOAD | DONE) → IDLE.
- **IDLE:** waits for `start`. On `start`:
  - `img_idx`, `layer_idx` ← 0.
  - `cur_width` ← `IMG_WIDTH`, `cur_height` ← `IMG_HEIGHT`.
- **LOAD:**
  - `cur_pool` ← `pool_tbl[layer_idx]`.
  - Expected beat count `exp_cnt` ← `cur_pool ? (cur_width>>1)*(cur_height>>1) : cur_width*cur_height`, truncated to `CNT_W`.
  - Beat counter ← 0.
- **KICK:** `eng_start`=1 for exactly one cycle, then RUN.
- **RUN:**
  - Each cycle with `eng_valid_out`=1 increments the beat counter.
  - When the counter reaches `exp_cnt`, go to NEXT.
  - A valid on the same cycle the count is reached is the last beat; it is not carried over.
- **NEXT:**
  - If `cur_pool`, halve `cur_width` and `cur_height` (shift right by 1, floor).
  - If `layer_idx` < `NUM_LAYER-1`: `layer_idx`++ and go to LOAD.
  - Else if `img_idx` < `NUM_IMG-1`: `img_idx`++, `layer_idx` ← 0, reload `IMG_WIDTH`/`IMG_HEIGHT`, go to LOAD.
  - Else go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Pool table:** `pool_tbl` is VGG16 (pool after layers 1, 3, 6, 9, 12), held in the shared package.
- **`eng_stall`:** equals `out_full` while in RUN; 0 in every other state.
- **Ignored and error inputs:**
  - `start` is ignored outside IDLE.
  - `eng_valid_out` outside RUN is ignored and is not counted.
- **Reset:** applies in any state, including mid-layer. All outputs return to their reset values on the next edge and any partial count is discarded.

## Timing
- **Reset values:**
  - `eng_start`, `eng_stall`, `busy`, `done`, `cur_pool` = 0.
  - `layer_idx`, `img_idx` = 0.
  - `cur_width` = `IMG_WIDTH`, `cur_height` = `IMG_HEIGHT`.
  - FSM in IDLE.
- **Outputs:** all registered, except `eng_stall`, which is combinational from `out_full` and the state.
- **Start latency:** `start` at cycle t gives `busy`=1 at t+1 and `eng_start` at t+3 (LOAD at t+1, KICK at t+2 drives the pulse at the following edge).
- **Layer latency:** from the last counted beat to the next `eng_start` is 3 cycles (NEXT, LOAD, KICK).
- **`busy`:** falls in the same cycle `done` pulses.
- **Config stability:** `cur_width`, `cur_height`, `cur_pool`, `layer_idx` are stable from LOAD through the end of RUN. The engine samples them at `eng_start`.

## Structure
- **Shared package `vgg_pkg`:**
  - State encoding enum.
  - `POOL_TBL` constant bit vector.
  - Default `IMG_WIDTH`/`IMG_HEIGHT`/`NUM_LAYER`.
  - The same constants already used by the dimension header.
- **Sub-module `layer_cfg_rom`:** combinational lookup of `layer_idx` → `pool`, so that channel counts can be added later without touching the FSM.

## Test plan
- **Basic sequence:** reset, then `start` with `NUM_LAYER`=3, `NUM_IMG`=1, 4x4 image, pool after layer 1, engine returning `exp_cnt` valids.
  - Expect `eng_start` ×3.
  - Expect `cur_width`/`cur_height` = 4,4 → 4,4 → 2,2.
  - Expect `exp_cnt` = 16, 4, 4.
  - Expect `done` once, `busy` low afterwards.
- **Multi-image:** `NUM_IMG`=2 → `layer_idx` wraps to 0, `img_idx`=1, dims reload to 4x4, 6 `eng_start` pulses total, a single `done`.
- **Back-pressure:** hold `out_full`=1 for 10 cycles during RUN → `eng_stall`=1 for exactly those cycles. Valids are still counted and the layer completes at the correct count.
- **Spurious inputs:** `start` pulsed during RUN and `eng_valid_out` asserted in IDLE/LOAD → no effect on state, counts or outputs.
- **Reset mid-layer:** reset asserted in RUN after 5 of 16 beats → all outputs at reset values next cycle. A fresh `start` runs the full sequence from layer 0.
- **Full VGG16 defaults:** 224x224, 13 layers → final `cur_width`=7 and `done` after the 13th layer completes.

Source files
------------

// File: rtl/vgg_pkg.sv
// Shared VGG16 sequencing definitions: FSM state encoding, network defaults and
// the per-layer max-pool table used by the layer sequencer and its config ROM.
package vgg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_RUN,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam int VGG_NUM_LAYER  = 13;
  localparam int VGG_IMG_WIDTH  = 224;
  localparam int VGG_IMG_HEIGHT = 224;

  // Bit i set: conv layer i is followed by a 2x2 max-pool (layers 1,3,6,9,12).
  localparam int unsigned POOL_TBL_W = 16;
  localparam logic [POOL_TBL_W-1:0] POOL_TBL = 16'h124A;

  function automatic logic pool_at(input int unsigned idx);
    return (idx < POOL_TBL_W) ? POOL_TBL[idx[3:0]] : 1'b0;
  endfunction

endpackage

// File: rtl/layer_cfg_rom.sv
// Combinational per-layer configuration lookup; kept separate from the FSM so
// further per-layer fields (e.g. channel counts) can be added here alone.
module layer_cfg_rom
  import vgg_pkg::*;
#(
  parameter int LW = 4
) (
  input  logic [LW-1:0] layer_idx_i,
  output logic          pool_o
);

  assign pool_o = pool_at(32'(layer_idx_i));

endmodule

// File: rtl/vgg_layer_sequencer.sv
// VGG16 layer sequencer. States: IDLE wait start | LOAD fetch pool, size layer |
// KICK pulse eng_start | RUN count output beats | NEXT advance layer/image | DONE pulse done.
module vgg_layer_sequencer
  import vgg_pkg::*;
#(
  parameter int NUM_LAYER  = VGG_NUM_LAYER,
  parameter int NUM_IMG    = 1,
  parameter int IMG_WIDTH  = VGG_IMG_WIDTH,
  parameter int IMG_HEIGHT = VGG_IMG_HEIGHT,
  parameter int DIM_W      = 9,
  parameter int CNT_W      = 16,
  localparam int LW = (NUM_LAYER > 1) ? $clog2(NUM_LAYER) : 1,
  localparam int IW = $clog2(NUM_IMG) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             eng_valid_out_i,
  input  logic             out_full_i,
  output logic             eng_start_o,
  output logic             eng_stall_o,
  output logic [LW-1:0]    layer_idx_o,
  output logic [IW-1:0]    img_idx_o,
  output logic [DIM_W-1:0] cur_width_o,
  output logic [DIM_W-1:0] cur_height_o,
  output logic             cur_pool_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int AW = 2 * DIM_W;
  localparam logic [DIM_W-1:0] W0 = DIM_W'(IMG_WIDTH);
  localparam logic [DIM_W-1:0] H0 = DIM_W'(IMG_HEIGHT);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYER - 1);
  localparam logic [IW-1:0] LAST_IMG   = IW'(NUM_IMG - 1);

  state_e           state_q;
  logic [LW-1:0]    layer_q;
  logic [IW-1:0]    img_q;
  logic [DIM_W-1:0] width_q, height_q;
  logic             pool_q, eng_start_q, busy_q, done_q;
  logic [CNT_W-1:0] exp_q, cnt_q;

  logic             pool_w;
  logic [AW-1:0]    area_full, area_pool;
  logic [CNT_W-1:0] exp_cnt_d, cnt_d;

  layer_cfg_rom #(.LW(LW)) u_cfg_rom (
    .layer_idx_i (layer_q),
    .pool_o      (pool_w)
  );

  // Pooled layers emit a quarter of their input pixels.
  assign area_full = AW'(width_q) * AW'(height_q);
  assign area_pool = AW'(width_q >> 1) * AW'(height_q >> 1);
  assign exp_cnt_d = pool_w ? CNT_W'(area_pool) : CNT_W'(area_full);
  assign cnt_d     = cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      layer_q     <= '0;
      img_q       <= '0;
      width_q     <= W0;
      height_q    <= H0;
      pool_q      <= 1'b0;
      exp_q       <= '0;
      cnt_q       <= '0;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            busy_q   <= 1'b1;
            layer_q  <= '0;
            img_q    <= '0;
            width_q  <= W0;
            height_q <= H0;
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          pool_q  <= pool_w;
          exp_q   <= exp_cnt_d;
          cnt_q   <= '0;
          state_q <= ST_KICK;
        end
        ST_KICK: begin
          eng_start_q <= 1'b1;
          state_q     <= ST_RUN;
        end
        ST_RUN: begin
          if (eng_valid_out_i) begin
            cnt_q <= cnt_d;
            if (cnt_d == exp_q) state_q <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (pool_q) begin
            width_q  <= width_q >> 1;
            height_q <= height_q >> 1;
          end
          // A new image overrides the pooled halving with the full input size.
          if (layer_q != LAST_LAYER) begin
            layer_q <= layer_q + LW'(1);
            state_q <= ST_LOAD;
          end else if (img_q != LAST_IMG) begin
            img_q    <= img_q + IW'(1);
            layer_q  <= '0;
            width_q  <= W0;
            height_q <= H0;
            state_q  <= ST_LOAD;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign eng_stall_o  = out_full_i && (state_q == ST_RUN);
  assign eng_start_o  = eng_start_q;
  assign layer_idx_o  = layer_q;
  assign img_idx_o    = img_q;
  assign cur_width_o  = width_q;
  assign cur_height_o = height_q;
  assign cur_pool_o   = pool_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_vgg_layer_sequencer.sv
// Self-checking bench: three sequencer configurations driven with random beats,
// stalls and spurious inputs, checked against a layer-by-layer timeline model.
module tb_vgg_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start = 1'b0, valid = 1'b0, full = 1'b0;
  int   sel = 0;
  int   checks = 0, errors = 0;

  // Configs: 0 = 3 layers/1 image 4x4, 1 = 3 layers/2 images 4x4, 2 = 13 layers 224x64
  int nl_t[3] = '{3, 3, 13};
  int ni_t[3] = '{1, 2, 1};
  int w0_t[3] = '{4, 4, 224};
  int h0_t[3] = '{4, 4, 64};

  logic       a_es, a_st, a_pool, a_busy, a_done;
  logic [1:0] a_layer;
  logic [0:0] a_img;
  logic [8:0] a_w, a_h;
  logic       b_es, b_st, b_pool, b_busy, b_done;
  logic [1:0] b_layer;
  logic [1:0] b_img;
  logic [8:0] b_w, b_h;
  logic       c_es, c_st, c_pool, c_busy, c_done;
  logic [3:0] c_layer;
  logic [0:0] c_img;
  logic [8:0] c_w, c_h;

  vgg_layer_sequencer #(.NUM_LAYER(3), .NUM_IMG(1), .IMG_WIDTH(4), .IMG_HEIGHT(4),
                        .DIM_W(9), .CNT_W(16)) u_a (
    .clk_i(clk), .reset_i(reset), .start_i(start && sel == 0),
    .eng_valid_out_i(valid && sel == 0), .out_full_i(full && sel == 0),
    .eng_start_o(a_es), .eng_stall_o(a_st), .layer_idx_o(a_layer), .img_idx_o(a_img),
    .cur_width_o(a_w), .cur_height_o(a_h), .cur_pool_o(a_pool), .busy_o(a_busy), .done_o(a_done));

  vgg_layer_sequencer #(.NUM_LAYER(3), .NUM_IMG(2), .IMG_WIDTH(4), .IMG_HEIGHT(4),
                        .DIM_W(9), .CNT_W(16)) u_b (
    .clk_i(clk), .reset_i(reset), .start_i(start && sel == 1),
    .eng_valid_out_i(valid && sel == 1), .out_full_i(full && sel == 1),
    .eng_start_o(b_es), .eng_stall_o(b_st), .layer_idx_o(b_layer), .img_idx_o(b_img),
    .cur_width_o(b_w), .cur_height_o(b_h), .cur_pool_o(b_pool), .busy_o(b_busy), .done_o(b_done));

  vgg_layer_sequencer #(.NUM_LAYER(13), .NUM_IMG(1), .IMG_WIDTH(224), .IMG_HEIGHT(64),
                        .DIM_W(9), .CNT_W(16)) u_c (
    .clk_i(clk), .reset_i(reset), .start_i(start && sel == 2),
    .eng_valid_out_i(valid && sel == 2), .out_full_i(full && sel == 2),
    .eng_start_o(c_es), .eng_stall_o(c_st), .layer_idx_o(c_layer), .img_idx_o(c_img),
    .cur_width_o(c_w), .cur_height_o(c_h), .cur_pool_o(c_pool), .busy_o(c_busy), .done_o(c_done));

  logic [31:0] o_es, o_st, o_pool, o_busy, o_done, o_layer, o_img, o_w, o_h;
  always_comb begin
    o_es = 32'(a_es); o_st = 32'(a_st); o_pool = 32'(a_pool); o_busy = 32'(a_busy);
    o_done = 32'(a_done); o_layer = 32'(a_layer); o_img = 32'(a_img);
    o_w = 32'(a_w); o_h = 32'(a_h);
    if (sel == 1) begin
      o_es = 32'(b_es); o_st = 32'(b_st); o_pool = 32'(b_pool); o_busy = 32'(b_busy);
      o_done = 32'(b_done); o_layer = 32'(b_layer); o_img = 32'(b_img);
      o_w = 32'(b_w); o_h = 32'(b_h);
    end else if (sel == 2) begin
      o_es = 32'(c_es); o_st = 32'(c_st); o_pool = 32'(c_pool); o_busy = 32'(c_busy);
      o_done = 32'(c_done); o_layer = 32'(c_layer); o_img = 32'(c_img);
      o_w = 32'(c_w); o_h = 32'(c_h);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s (cfg %0d): observed %0d expected %0d", tag, sel, obs, expv);
    end
  endtask

  // One cycle: inputs applied just after the falling edge, outputs read 1 ns later.
  task automatic cyc(input logic st, input logic v, input logic f);
    @(negedge clk);
    start = st; valid = v; full = f;
    #1;
  endtask

  function automatic int is_pool(input int l);
    return (l == 1 || l == 3 || l == 6 || l == 9 || l == 12) ? 1 : 0;
  endfunction

  function automatic logic rnd(input int one_in);
    return ($urandom_range(0, one_in - 1) == 0);
  endfunction

  task automatic chk_reset_vals(input int s);
    sel = s; #1;
    chk("rst_eng_start", o_es, 0);
    chk("rst_stall", o_st, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_pool", o_pool, 0);
    chk("rst_layer", o_layer, 0);
    chk("rst_img", o_img, 0);
    chk("rst_width", o_w, 32'(w0_t[s]));
    chk("rst_height", o_h, 32'(h0_t[s]));
  endtask

  task automatic run_seq(input int s, input int bp);
    int w, h, p, e, cnt, stall_n, run_c;
    logic v, f;
    sel = s;
    cyc(1'b1, 1'b1, $urandom_range(0, 1) == 1);
    chk("idle_busy", o_busy, 0);
    chk("idle_stall", o_st, 0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("load_busy", o_busy, 1);
    chk("load_eng_start", o_es, 0);
    chk("load_stall", o_st, 0);
    chk("load_layer", o_layer, 0);
    chk("load_width", o_w, 32'(w0_t[s]));
    cyc(1'b1, 1'b1, 1'b1);
    chk("kick_eng_start", o_es, 0);
    chk("kick_stall", o_st, 0);
    w = 0; h = 0;
    for (int img = 0; img < ni_t[s]; img++) begin
      w = w0_t[s]; h = h0_t[s];
      for (int l = 0; l < nl_t[s]; l++) begin
        p = is_pool(l);
        e = (p != 0) ? (w / 2) * (h / 2) : w * h;
        cnt = 0; stall_n = 0;
        for (run_c = 0; cnt < e && run_c < e * 8 + 64; run_c++) begin
          v = !rnd(4);
          f = (bp != 0 && img == 0 && l == 0) ? (run_c >= 2 && run_c < 12) : rnd(4);
          cyc(rnd(16), v, f);
          chk("run_eng_start", o_es, (run_c == 0) ? 1 : 0);
          chk("run_stall", o_st, f ? 1 : 0);
          if (o_st == 1) stall_n++;
          if (run_c == 0) begin
            chk("layer_idx", o_layer, 32'(l));
            chk("img_idx", o_img, 32'(img));
            chk("cur_width", o_w, 32'(w));
            chk("cur_height", o_h, 32'(h));
            chk("cur_pool", o_pool, 32'(p));
            chk("run_busy", o_busy, 1);
          end
          if (v) cnt++;
        end
        if (cnt < e) begin
          checks++; errors++;
          $error("FAIL beat_budget (cfg %0d): sent %0d beats expected %0d", sel, cnt, e);
        end
        chk("last_beat_layer", o_layer, 32'(l));
        chk("last_beat_width", o_w, 32'(w));
        if (bp != 0 && img == 0 && l == 0) chk("stall_cycles", 32'(stall_n), 10);
        if (p != 0) begin w = w / 2; h = h / 2; end
        cyc(rnd(4), 1'b1, 1'b1);
        chk("next_eng_start", o_es, 0);
        chk("next_stall", o_st, 0);
        chk("next_busy", o_busy, 1);
        chk("next_done", o_done, 0);
        if (img == ni_t[s] - 1 && l == nl_t[s] - 1) begin
          cyc(1'b0, 1'b1, 1'b1);
          chk("done_pulse", o_done, 1);
          chk("done_busy", o_busy, 0);
          chk("done_eng_start", o_es, 0);
          cyc(1'b0, 1'b1, 1'b0);
          chk("after_done", o_done, 0);
          chk("after_busy", o_busy, 0);
          chk("final_width", o_w, 32'(w));
          chk("final_height", o_h, 32'(h));
        end else begin
          cyc(rnd(4), 1'b1, 1'b1);
          chk("gap_load_eng_start", o_es, 0);
          chk("gap_load_stall", o_st, 0);
          cyc(rnd(4), 1'b1, 1'b1);
          chk("gap_kick_eng_start", o_es, 0);
        end
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) chk_reset_vals(s);
    reset = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    sel = 0; #1;
    chk("idle_valid_ignored_busy", o_busy, 0);

    // basic sequence with a 10-cycle back-pressure window in layer 0
    run_seq(0, 1);

    // reset in RUN after 5 of 16 beats, then a full fresh run
    sel = 0;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("pre_reset_busy", o_busy, 1);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    chk_reset_vals(0);
    run_seq(0, 0);

    run_seq(1, 0);
    run_seq(2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
